// File: rtl/luhn_pkg.sv
// rtl/luhn_pkg.sv - shared digit type and modulus for the Luhn generator and validator
package luhn_pkg;

    typedef logic [3:0] digit_t;

    localparam int LUHN_MOD = 10;

endpackage

// File: rtl/luhn_dbl_digit.sv
// rtl/luhn_dbl_digit.sv - Luhn doubling: 2d for d<=4, else 2d-9, truncated to 4 bits
module luhn_dbl_digit
    import luhn_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    localparam logic [4:0] FOLD = 5'(LUHN_MOD - 1);

    logic [4:0] w_dbl;

    assign w_dbl   = {i_digit, 1'b0};
    // Non-BCD inputs fall through the same map and simply wrap at 4 bits.
    assign o_digit = (i_digit <= 4'd4) ? w_dbl[3:0] : 4'(w_dbl - FOLD);

endmodule

// File: rtl/luhn_check_gen.sv
// rtl/luhn_check_gen.sv - streaming Luhn check-digit generator; optional LUHN_GEN_BCD_CHECK_EN flags non-BCD digits
module luhn_check_gen
    import luhn_pkg::*;
#(
    parameter int NUM_DIGITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_check,
    output logic       out_err
);

    localparam int               CNT_W    = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 2);
    localparam logic             LAST_ODD = 1'((NUM_DIGITS - 1) % 2);
    localparam logic [4:0]       MOD5     = 5'(LUHN_MOD);
    localparam logic [4:0]       MOD5X2   = 5'(2 * LUHN_MOD);

    localparam logic S_COLLECT = 1'b0;
    localparam logic S_RESULT  = 1'b1;

    logic             r_state;
    logic [CNT_W-1:0] r_cnt;
    digit_t           r_sum;

    digit_t     w_folded;
    digit_t     w_term;
    digit_t     w_sum_next;
    logic       w_double;
    logic       w_accept;
    logic [4:0] w_acc;

    luhn_dbl_digit u_dbl (
        .i_digit (in_digit),
        .o_digit (w_folded)
    );

    // Digit k is doubled when its distance from the check digit is odd.
    assign w_double = r_cnt[0] ^ LAST_ODD;
    assign w_accept = in_valid && (r_state == S_COLLECT);

`ifdef LUHN_GEN_BCD_CHECK_EN
    logic r_err;
    logic w_bad;

    assign w_bad   = in_digit > 4'd9;
    assign w_term  = w_bad ? 4'd0 : (w_double ? w_folded : in_digit);
    assign out_err = out_valid && r_err;
`else
    assign w_term  = w_double ? w_folded : in_digit;
    assign out_err = 1'b0;
`endif

    // Term can reach 15 without the BCD check, so the sum may need two folds.
    assign w_acc      = {1'b0, r_sum} + {1'b0, w_term};
    assign w_sum_next = (w_acc >= MOD5X2) ? 4'(w_acc - MOD5X2) :
                        (w_acc >= MOD5)   ? 4'(w_acc - MOD5)   : w_acc[3:0];

    assign in_ready  = (r_state == S_COLLECT);
    assign out_valid = (r_state == S_RESULT);
    assign out_check = !out_valid    ? 4'd0 :
                       (r_sum == '0) ? 4'd0 : 4'(MOD5 - {1'b0, r_sum});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_sum   <= '0;
`ifdef LUHN_GEN_BCD_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else if (flush) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_sum   <= '0;
`ifdef LUHN_GEN_BCD_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else if (r_state == S_COLLECT) begin
            if (w_accept) begin
                r_sum <= w_sum_next;
`ifdef LUHN_GEN_BCD_CHECK_EN
                r_err <= r_err | w_bad;
`endif
                if (r_cnt == LAST_IDX) begin
                    r_state <= S_RESULT;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_sum   <= '0;
`ifdef LUHN_GEN_BCD_CHECK_EN
            r_err   <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/luhn_check_gen.md
LUHN_CHECK_GEN -- requirements
Module: luhn_check_gen

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 16, meaning total card length including the check digit; legal range 2..19.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port flush, input, 1, synchronous abort of the card in progress.
REQ-005 SHALL have port in_valid, input, 1, payload digit present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a digit.
REQ-007 SHALL have port in_digit, input, 4, BCD payload digit, most-significant digit first.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port out_check, output, 4, computed Luhn check digit, 0..9.
REQ-011 SHALL have port out_err, output, 1, a non-BCD digit was seen in this card.

Function
REQ-012 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and RESULT (in_ready=0, out_valid=1).
REQ-013 SHALL accept a digit only on a cycle where in_valid and in_ready are both 1 in COLLECT.
REQ-014 SHALL count accepted digits 0..NUM_DIGITS-2, with a counter width of $clog2(NUM_DIGITS).
REQ-015 SHALL double the k-th accepted digit (k from 0) when (NUM_DIGITS-1-k) is odd; the doubled value maps to 2d if d<=4, else 2d-9.
REQ-016 SHALL keep a 4-bit running sum reduced mod 10 every accepted digit, so it never exceeds 9.
REQ-017 SHALL transition COLLECT->RESULT on acceptance of digit NUM_DIGITS-2, so out_valid is asserted the cycle after the last handshake.
REQ-018 SHALL drive out_check=(10-sum)mod 10 using the final sum, held stable while out_valid=1.
REQ-019 SHALL hold out_check and out_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL on out_valid&&out_ready: return to COLLECT next cycle, clear sum, counter and error, and raise in_ready that cycle.
REQ-021 SHALL on flush=1 return to COLLECT and clear sum, counter and error next cycle from any state; flush overrides a simultaneous input or output handshake, and the digit or result is discarded.
REQ-022 SHALL ignore in_digit while in_valid=0 or in_ready=0.

Reset
REQ-023 SHALL on rst=1 immediately enter COLLECT with sum=0, count=0, err=0, out_valid=0, out_check=0, out_err=0, in_ready=1.
REQ-024 SHALL discard a partially collected card on reset mid-operation; the first digit after release is treated as the card's most-significant digit.

Configuration
REQ-025 SHALL, with LUHN_GEN_BCD_CHECK_EN defined, set the sticky error flag when an accepted digit >9; the digit adds 0 to the sum, and out_err reports the flag in RESULT.
REQ-026 SHALL, without LUHN_GEN_BCD_CHECK_EN, tie out_err to 0, add no check logic, and process digits >9 with the same map truncated to 4 bits.

Structure
REQ-027 SHALL place digit_t (logic [3:0]) and the constant LUHN_MOD=10 in shared package luhn_pkg.
REQ-028 SHALL instantiate one combinational sub-module luhn_dbl_digit (digit in, doubled-and-folded digit out), reusable by the validator.

Verification
REQ-029 SHALL check: NUM_DIGITS=16, payload 4,1,1,1,1,1,1,1,1,1,1,1,1,1,1 streamed back-to-back -> out_check=1, out_err=0, out_valid the cycle after the 15th handshake.
REQ-030 SHALL check: NUM_DIGITS=11, payload 7,9,9,2,7,3,9,8,7,1 -> out_check=3.
REQ-031 SHALL check: fifteen 0 digits with random in_valid gaps, and out_ready held 0 for 5 cycles -> out_check=0 stable, in_ready=0 throughout, accepted next cycle after out_ready=1.
REQ-032 SHALL check: with LUHN_GEN_BCD_CHECK_EN, 0xA at digit 3 -> out_err=1; the following card is clean -> out_err=0.
REQ-033 SHALL check: rst pulse after digit 7, and separately flush coincident with the final handshake -> no out_valid; a full new card then yields the correct result.
